mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and HI/LO register width.
REQ-002 Parameter MULT_CYCLES, default 5, SHALL set multiply latency in cycles (legal range 1..63).
REQ-003 Parameter DIV_CYCLES, default 10, SHALL set divide latency in cycles (legal range 1..63).
REQ-004 Ports SHALL be exactly as follows (name, direction, width, meaning):
  clk    input   1      rising-edge clock
  reset  input   1      asynchronous, active-high reset
  start  input   1      operation request, sampled at rising clk
  op     input   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
  a      input   WIDTH  operand A (dividend / multiplicand / MTxx data)
  b      input   WIDTH  operand B (divisor / multiplier)
  busy   output  1      operation in flight; the core stalls MDU instructions while high
  done   output  1      one-cycle pulse in the cycle HI/LO commit
  hi     output  WIDTH  HI register
  lo     output  WIDTH  LO register
REQ-005 Design SHALL use one clock, clk; reset SHALL be asynchronous and active-high.

Function
REQ-006 start SHALL be accepted only when busy=0; start while busy=1 SHALL be ignored without side effects.
REQ-007 Accepted op 0-3 SHALL capture a, b and op at the accepting edge E, assert busy from E through edge E+N, and set N=MULT_CYCLES for ops 0-1 and N=DIV_CYCLES for ops 2-3.
REQ-008 At edge E+N, the unit SHALL write hi/lo, deassert busy, and pulse done for exactly one cycle. busy SHALL be high for exactly N cycles.
REQ-009 An internal down-counter SHALL track remaining cycles. Its width SHALL be 6 bits and it SHALL hold 0 when idle.
REQ-010 MULT SHALL form the signed 2*WIDTH product, and MULTU the unsigned product, with {hi,lo} = product.
REQ-011 DIV/DIVU SHALL write lo = quotient and hi = remainder. Signed quotient SHALL truncate toward zero, and signed remainder SHALL take the dividend's sign.
REQ-012 Signed overflow (a = most-negative, b = -1) SHALL give lo = most-negative and hi = 0.
REQ-013 Divide by zero SHALL still run DIV_CYCLES with busy and done behaving normally, and hi/lo SHALL be left unchanged.
REQ-014 Accepted MTHI/MTLO SHALL write a to hi/lo at the accepting edge, with no busy and no done.
REQ-015 Reserved op codes SHALL be ignored.
REQ-016 hi/lo SHALL change only at commit edges, MTxx edges or reset, so operand changes during busy have no effect.
REQ-017 A new start in the same cycle busy falls (busy=0 sampled) SHALL be accepted, giving back-to-back operations with no idle cycle.

Reset
REQ-018 When reset=1, the unit SHALL immediately force busy=0, done=0, hi=0, lo=0, and counter=0, independent of clk.
REQ-019 Reset mid-operation SHALL abort it, and no commit SHALL occur after reset releases.
REQ-020 start sampled while reset=1 SHALL be ignored.

Verification
REQ-021 MULT a=0xFFFFFFFE (-2), b=3, default parameters -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, and done pulses once.
REQ-022 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
REQ-023 DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with the same operands gives lo=0x7FFFFFFC, hi=0x00000001.
REQ-024 Corner cases: MTHI a=0x1234 then DIV b=0 -> hi stays 0x1234 with busy 10 cycles. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-025 Start MULT, then assert reset asynchronously at cycle 3 -> busy, hi and lo drop to 0 before the next clk edge, and no done follows.
REQ-026 Re-instantiate with WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3. start while busy is ignored, back-to-back MULT is accepted on the busy-fall cycle, and 0x8000*0x8000 signed gives hi=0x4000, lo=0x0000.

Source files
------------

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Results commit after a fixed latency; MTHI/MTLO write directly when idle.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [5:0] MULT_N = 6'(MULT_CYCLES);
  localparam logic [5:0] DIV_N  = 6'(DIV_CYCLES);

  logic [5:0]       count;
  logic [1:0]       op_q;   // bit0: unsigned, bit1: divide
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             accept;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   uq;
  logic [WIDTH-1:0]   ur;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign busy   = (count != 6'd0);
  assign accept = start && !busy;

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    a_neg   = !op_q[0] && a_q[WIDTH-1];
    b_neg   = !op_q[0] && b_q[WIDTH-1];
    ext_a   = {{WIDTH{a_neg}}, a_q};
    ext_b   = {{WIDTH{b_neg}}, b_q};
    product = ext_a * ext_b;
    // Signed divide works on magnitudes; the most-negative / -1 case wraps back to most-negative.
    dvd     = a_neg ? -a_q : a_q;
    dvs     = b_neg ? -b_q : b_q;
    uq      = dvd / dvs;
    ur      = dvd % dvs;
    quo     = (a_neg ^ b_neg) ? -uq : uq;
    rem     = a_neg ? -ur : ur;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 6'd0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= 2'd0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            count <= MULT_N;
            op_q  <= op[1:0];
            a_q   <= a;
            b_q   <= b;
          end
          OP_DIV, OP_DIVU: begin
            count <= DIV_N;
            op_q  <= op[1:0];
            a_q   <= a;
            b_q   <= b;
          end
          OP_MTHI: hi <= a;
          OP_MTLO: lo <= a;
          default: ;
        endcase
      end else if (count == 6'd1) begin
        count <= 6'd0;
        done  <= 1'b1;
        if (!op_q[1]) begin
          {hi, lo} <= product;
        end else if (b_q != '0) begin
          hi <= rem;
          lo <= quo;
        end
      end else if (busy) begin
        count <= count - 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a 32-bit default instance and a 16-bit fast instance,
// with expected HI/LO values queued at issue and compared at commit.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start32, start16;
  logic [2:0]  op32, op16;
  logic [31:0] a32, b32, hi32, lo32;
  logic [15:0] a16, b16, hi16, lo16;
  logic        busy32, done32, busy16, done16;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  mul_div_unit dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  mul_div_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .hi(hi16), .lo(lo16)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, want);
    end
  endtask

  // Issue a multi-cycle op on the 32-bit unit, scramble operands while busy, check commit.
  task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] av, bv,
                       input logic [31:0] eh, el, input int n);
    int cyc = 0;
    int early = 0;
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = av; b32 = bv;
    sb.push_back({eh, el});
    @(posedge clk); #1;
    start32 = 1'b0;
    while (cyc <= 100) begin
      @(negedge clk);
      if (!busy32) break;
      cyc++;
      if (done32) early++;
      a32 = $urandom; b32 = $urandom;
    end
    check({tag, "_busy_len"}, 64'(cyc), 64'(n));
    check({tag, "_no_early_done"}, 64'(early), 64'd0);
    check({tag, "_done"}, 64'(done32), 64'd1);
    check({tag, "_hilo"}, {hi32, lo32}, sb.pop_front());
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done32), 64'd0);
  endtask

  // Single-edge op (MTHI/MTLO/reserved) on the 32-bit unit.
  task automatic mt32(input string tag, input logic [2:0] o, input logic [31:0] av,
                      input logic [31:0] eh, el);
    @(negedge clk);
    start32 = 1'b1; op32 = o; a32 = av;
    @(posedge clk); #1;
    start32 = 1'b0;
    check({tag, "_busy"}, 64'(busy32), 64'd0);
    check({tag, "_hilo"}, {hi32, lo32}, {eh, el});
    @(negedge clk);
    check({tag, "_done"}, 64'(done32), 64'd0);
  endtask

  // Wait for the 16-bit unit to drop busy, then compare against the scoreboard.
  task automatic wait16(input string tag);
    int cyc = 0;
    while (busy16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_busy_drop"}, 64'(busy16), 64'd0);
    check({tag, "_done"}, 64'(done16), 64'd1);
    check({tag, "_hilo"}, {32'h0, hi16, lo16}, sb.pop_front());
  endtask

  initial begin
    int dcount;
    int bcount;
    clk = 1'b0; reset = 1'b0;
    start32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
    start16 = 1'b0; op16 = 3'd0; a16 = '0; b16 = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_busy32", 64'(busy32), 64'd0);
    check("rst_done32", 64'(done32), 64'd0);
    check("rst_hilo32", {hi32, lo32}, 64'd0);
    check("rst_busy16", 64'(busy16), 64'd0);
    check("rst_hilo16", {32'h0, hi16, lo16}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run32("mult",   3'd0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
    run32("multu",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
    run32("div",    3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
    run32("divu",   3'd3, 32'hFFFF_FFF9, 32'd2,        32'h0000_0001, 32'h7FFF_FFFC, 10);
    mt32("mthi",    3'd4, 32'h0000_1234,               32'h0000_1234, 32'h7FFF_FFFC);
    run32("div0",   3'd2, 32'h0000_0055, 32'd0,        32'h0000_1234, 32'h7FFF_FFFC, 10);
    run32("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10);
    mt32("mtlo",    3'd5, 32'h0000_CAFE,               32'h0000_0000, 32'h0000_CAFE);
    mt32("rsvd",    3'd7, 32'hDEAD_BEEF,               32'h0000_0000, 32'h0000_CAFE);

    // Load nonzero HI/LO, then abort a MULT with an asynchronous reset.
    mt32("mthi2",   3'd4, 32'h0000_00AA,               32'h0000_00AA, 32'h0000_CAFE);
    @(negedge clk);
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("arst_busy", 64'(busy32), 64'd0);
    check("arst_hilo", {hi32, lo32}, 64'd0);
    start32 = 1'b1; op32 = 3'd4; a32 = 32'h5;
    @(posedge clk);
    @(negedge clk);
    check("arst_start_ignored", {hi32, lo32}, 64'd0);
    start32 = 1'b0;
    reset = 1'b0;
    dcount = 0;
    bcount = 0;
    repeat (8) begin
      @(negedge clk);
      dcount += int'(done32);
      bcount += int'(busy32);
    end
    check("arst_no_done", 64'(dcount), 64'd0);
    check("arst_no_busy", 64'(bcount), 64'd0);
    check("arst_hilo_after", {hi32, lo32}, 64'd0);

    // 16-bit unit: signed 0x8000 * 0x8000.
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd0; a16 = 16'h8000; b16 = 16'h8000;
    sb.push_back({32'h0, 16'h4000, 16'h0000});
    @(posedge clk); #1;
    start16 = 1'b0;
    @(negedge clk);
    wait16("m16");

    // DIV 100/7 with an MTLO request held into the busy window.
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd2; a16 = 16'd100; b16 = 16'd7;
    sb.push_back({32'h0, 16'h0002, 16'h000E});
    @(posedge clk); #1;
    op16 = 3'd5; a16 = 16'hBEEF;
    @(posedge clk); #1;
    start16 = 1'b0;
    @(negedge clk);
    check("d16_busy_mid", 64'(busy16), 64'd1);
    wait16("d16");

    // Back-to-back MULTs: second start held through busy, accepted on the busy-fall cycle.
    @(negedge clk);
    start16 = 1'b1; op16 = 3'd0; a16 = 16'd3; b16 = 16'hFFFB;
    sb.push_back({32'h0, 16'hFFFF, 16'hFFF1});
    @(posedge clk); #1;
    a16 = 16'd7; b16 = 16'd9;
    sb.push_back({32'h0, 16'h0000, 16'h003F});
    @(negedge clk);
    check("b2b_busy_first", 64'(busy16), 64'd1);
    @(negedge clk);
    wait16("b2b_first");
    @(posedge clk); #1;
    start16 = 1'b0;
    @(negedge clk);
    check("b2b_accept", 64'(busy16), 64'd1);
    check("b2b_done_low", 64'(done16), 64'd0);
    @(negedge clk);
    wait16("b2b_second");
    @(negedge clk);
    check("b2b_done_pulse", 64'(done16), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
